note_scroller: RTL and testbench

- Parametrised multi-lane note chart scroller for the rhythm-game datapath; generalises the single-vector note shifter to LANES independent lanes.
- Holds one chart per lane, advances all lanes one row per `step` strobe, and exposes a WINDOW-row display slice per lane.
- Adds a strike row with hit/miss detection, pause, end-of-chart detection and a loop mode that replays the loaded chart.
- Sits between the chart ROM loader and the VGA note renderer / score counter.

---
 rtl/note_scroller.sv | 129 ++++++++++++
 tb/tb_note_scroller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/note_scroller.sv
`default_nettype none
// ============================================================================
// Module   : note_scroller
// Purpose  : Multi-lane rhythm-game chart scroller with strike row, hit/miss
//            pulses, pause, end-of-chart detection and looping replay.
// Revision : 1.0
// ============================================================================
module note_scroller #(
    parameter int LANES  = 5,
    parameter int DEPTH  = 105,
    parameter int WINDOW = 15,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      load,
    input  logic [LANES*DEPTH-1:0]    chart_in,
    input  logic                      step,
    input  logic                      enable,
    input  logic                      loop_mode,
    input  logic [LANES-1:0]          hit_mask,
    output logic [LANES*WINDOW-1:0]   window_out,
    output logic [LANES-1:0]          strike_row,
    output logic [LANES-1:0]          hit_ok,
    output logic [LANES-1:0]          hit_bad,
    output logic [LANES-1:0]          miss_pulse,
    output logic [CNT_W-1:0]          steps_left,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PLAY  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [DEPTH-1:0] C_MSB  = DEPTH'(1) << (DEPTH - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    state_t                        state_q;
    logic [LANES-1:0][DEPTH-1:0]   live_q;
    logic [LANES-1:0][DEPTH-1:0]   live_d;
    logic [LANES-1:0][DEPTH-1:0]   shadow_q;
    logic [CNT_W-1:0]              pos_q;
    logic [CNT_W-1:0]              pos_d;
    logic [CNT_W-1:0]              steps_q;
    logic                          done_q;
    logic [LANES-1:0]              hit_ok_q,  hit_ok_d;
    logic [LANES-1:0]              hit_bad_q, hit_bad_d;
    logic [LANES-1:0]              miss_q,    miss_d;
    logic                          w_active;
    logic                          w_adv;
    logic [CNT_W-1:0]              w_fill_idx;

    // Load has priority, so an active cycle is play + enable without load.
    assign w_active   = (state_q == S_PLAY) && enable && !load;
    assign w_adv      = w_active && step;
    assign w_fill_idx = C_LAST - pos_q;
    assign pos_d      = (pos_q == C_LAST) ? '0 : pos_q + 1'b1;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic             w_strike;
        logic [DEPTH-1:0] w_post;
        logic [DEPTH-1:0] w_shadow_sh;
        logic             w_fill;

        assign w_strike     = live_q[l][DEPTH-1];
        assign hit_ok_d[l]  = w_active && hit_mask[l] && w_strike;
        assign hit_bad_d[l] = w_active && hit_mask[l] && !w_strike;
        // Hit is applied before the shift, so a struck note can never miss.
        assign w_post       = hit_ok_d[l] ? (live_q[l] & ~C_MSB) : live_q[l];
        assign w_shadow_sh  = shadow_q[l] >> w_fill_idx;
        assign w_fill       = loop_mode && w_shadow_sh[0];
        assign miss_d[l]    = w_adv && w_post[DEPTH-1];
        assign live_d[l]    = w_adv ? ((w_post << 1) | DEPTH'(w_fill)) : w_post;

        assign window_out[l*WINDOW +: WINDOW] = live_q[l][DEPTH-1 -: WINDOW];
        assign strike_row[l]                  = live_q[l][DEPTH-1];
    end : g_lane

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_EMPTY;
            live_q    <= '0;
            shadow_q  <= '0;
            pos_q     <= '0;
            steps_q   <= '0;
            done_q    <= 1'b1;
            hit_ok_q  <= '0;
            hit_bad_q <= '0;
            miss_q    <= '0;
        end else begin
            hit_ok_q  <= hit_ok_d;
            hit_bad_q <= hit_bad_d;
            miss_q    <= miss_d;
            if (load) begin
                live_q   <= chart_in;
                shadow_q <= chart_in;
                pos_q    <= '0;
                steps_q  <= C_FULL;
                done_q   <= 1'b0;
                state_q  <= S_PLAY;
            end else if (w_active) begin
                live_q <= live_d;
                if (step) begin
                    pos_q <= pos_d;
                    if (loop_mode) begin
                        steps_q <= C_FULL - pos_d;
                    end else begin
                        steps_q <= steps_q - 1'b1;
                        if (steps_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign hit_ok     = hit_ok_q;
    assign hit_bad    = hit_bad_q;
    assign miss_pulse = miss_q;
    assign steps_left = steps_q;
    assign done       = done_q;

endmodule : note_scroller
`default_nettype wire

// File: tb/tb_note_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_scroller
// Purpose  : Directed, table-driven self-checking bench for note_scroller
//            (LANES=2, DEPTH=8, WINDOW=4).
// Revision : 1.0
// ============================================================================
module tb_note_scroller;

    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                    clk;
    logic                    resetn;
    logic                    load;
    logic [LANES*DEPTH-1:0]  chart_in;
    logic                    step;
    logic                    enable;
    logic                    loop_mode;
    logic [LANES-1:0]        hit_mask;
    logic [LANES*WINDOW-1:0] window_out;
    logic [LANES-1:0]        strike_row;
    logic [LANES-1:0]        hit_ok;
    logic [LANES-1:0]        hit_bad;
    logic [LANES-1:0]        miss_pulse;
    logic [CNT_W-1:0]        steps_left;
    logic                    done;

    int checks;
    int failures;

    note_scroller #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .WINDOW(WINDOW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .chart_in  (chart_in),
        .step      (step),
        .enable    (enable),
        .loop_mode (loop_mode),
        .hit_mask  (hit_mask),
        .window_out(window_out),
        .strike_row(strike_row),
        .hit_ok    (hit_ok),
        .hit_bad   (hit_bad),
        .miss_pulse(miss_pulse),
        .steps_left(steps_left),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [15:0] chart;   // {lane1, lane0}
        logic        st;
        logic        en;
        logic        lp;
        logic [1:0]  hit;
        logic [7:0]  e_win;   // {lane1 window, lane0 window}
        logic [1:0]  e_strike;
        logic [1:0]  e_ok;
        logic [1:0]  e_bad;
        logic [1:0]  e_miss;
        logic [3:0]  e_steps;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ld, input logic [15:0] chart, input logic st,
                       input logic en, input logic lp, input logic [1:0] hit,
                       input logic [7:0] w, input logic [1:0] s, input logic [1:0] ok,
                       input logic [1:0] bad, input logic [1:0] miss,
                       input logic [3:0] sl, input logic d);
        vec_t v;
        v.ld = ld; v.chart = chart; v.st = st; v.en = en; v.lp = lp; v.hit = hit;
        v.e_win = w; v.e_strike = s; v.e_ok = ok; v.e_bad = bad; v.e_miss = miss;
        v.e_steps = sl; v.e_done = d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got win/strike/ok/bad/miss/steps/done=%h required %h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] outs();
        return {window_out, strike_row, hit_ok, hit_bad, miss_pulse, steps_left, done};
    endfunction

    task automatic drive(input logic ld, input logic [15:0] chart, input logic st,
                         input logic en, input logic lp, input logic [1:0] hit);
        load = ld; chart_in = chart; step = st; enable = en; loop_mode = lp; hit_mask = hit;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00);

        // ld chart st en lp hit | win strike ok bad miss steps done
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1); // step w/o chart
        add(1, 16'h01A0, 0, 1, 0, 2'b00, 8'h0A, 2'b01, 2'b00, 2'b00, 2'b00, 4'd8, 0); // load
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h04, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7, 0); // miss lane0
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h08, 2'b01, 2'b00, 2'b00, 2'b00, 4'd6, 0);
        add(0, 16'h0000, 0, 1, 0, 2'b11, 8'h00, 2'b00, 2'b01, 2'b10, 2'b00, 4'd6, 0); // hit ok/bad
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd5, 0); // cleared: no miss
        add(1, 16'h01C0, 1, 1, 0, 2'b11, 8'h0C, 2'b01, 2'b00, 2'b00, 2'b00, 4'd8, 0); // load masks step/hit
        add(0, 16'h0000, 1, 1, 0, 2'b01, 8'h08, 2'b01, 2'b01, 2'b00, 2'b00, 4'd7, 0); // hit+step
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd6, 0);
        add(1, 16'h01A0, 0, 1, 0, 2'b00, 8'h0A, 2'b01, 2'b00, 2'b00, 2'b00, 4'd8, 0); // full run
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h04, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h08, 2'b01, 2'b00, 2'b00, 2'b00, 4'd6, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd5, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h10, 2'b00, 2'b00, 2'b00, 2'b00, 4'd4, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h20, 2'b00, 2'b00, 2'b00, 2'b00, 4'd3, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h40, 2'b00, 2'b00, 2'b00, 2'b00, 4'd2, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h80, 2'b10, 2'b00, 2'b00, 2'b00, 4'd1, 0);
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b10, 4'd0, 1); // step 8: done
        add(0, 16'h0000, 1, 1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1); // step 9 ignored
        add(0, 16'h0000, 0, 1, 0, 2'b11, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1); // hit in DONE
        add(1, 16'h0081, 0, 1, 1, 2'b00, 8'h08, 2'b01, 2'b00, 2'b00, 2'b00, 4'd8, 0); // loop load
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7, 0); // 03
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd6, 0); // 06
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd5, 0); // 0C
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h01, 2'b00, 2'b00, 2'b00, 2'b00, 4'd4, 0); // 18
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h03, 2'b00, 2'b00, 2'b00, 2'b00, 4'd3, 0); // 30
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h06, 2'b00, 2'b00, 2'b00, 2'b00, 4'd2, 0); // 60
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h0C, 2'b01, 2'b00, 2'b00, 2'b00, 4'd1, 0); // C0
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h08, 2'b01, 2'b00, 2'b00, 2'b01, 4'd8, 0); // 81 wrap
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7, 0); // 03
        add(0, 16'h0000, 1, 0, 1, 2'b01, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7, 0); // paused
        add(0, 16'h0000, 1, 0, 1, 2'b01, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7, 0);
        add(0, 16'h0000, 1, 0, 1, 2'b01, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7, 0);
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd6, 0); // resume: 06
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd5, 0); // 0C
        add(0, 16'h0000, 1, 1, 1, 2'b00, 8'h01, 2'b00, 2'b00, 2'b00, 2'b00, 4'd4, 0); // 18

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), {8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1'b1});
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].chart, vecs[i].st, vecs[i].en, vecs[i].lp, vecs[i].hit);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_win, vecs[i].e_strike, vecs[i].e_ok, vecs[i].e_bad,
                   vecs[i].e_miss, vecs[i].e_steps, vecs[i].e_done});
        end

        // Mid-chart reset wins over a simultaneous load and step
        resetn = 1'b0;
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 2'b11);
        @(posedge clk);
        #1;
        check("reset_mid", outs(), {8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1'b1});
        resetn = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b11);
        @(posedge clk);
        #1;
        check("post_reset_step", outs(), {8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_note_scroller
`default_nettype wire
